clock_mode_fsm: RTL and testbench
=================================

# clock_mode_fsm

Parametrised mode controller for the digital clock: decodes the two debounced button pulses into clock-set, multi-alarm-set and stopwatch modes and drives the increment and stopwatch control strobes consumed by the timekeeping, alarm and stopwatch datapaths. It adds N alarm channels, hold-to-auto-repeat on the increment button, and an inactivity timeout that returns setting modes to normal display.

## Interface
- NUM_ALARMS, 2: alarm channels, 1..4.
- REPEAT_DELAY, 3: ticks B0 must be held before auto-repeat starts, ≥1.
- REPEAT_PERIOD, 1: ticks between auto-repeat strobes, ≥1.
- IDLE_TIMEOUT, 30: ticks without a button pulse before a setting mode aborts, ≥1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle time-base enable; counts repeat and timeout.
- B0  in  1  one-cycle pulse: mode/increment button.
- B1  in  1  one-cycle pulse: select/advance button.
- b0_held  in  1  debounced level of button 0.
- set_clock  out  1  in a clock-set state.
- alarm_set  out  NUM_ALARMS  one-hot; bit k set in alarm-k set states.
- alarm_sel  out  max(1,clog2(NUM_ALARMS))  current alarm index.
- inc_hour, inc_min  out  1  one-cycle increment strobes.
- stop, stop_start, stop_reset  out  1  stopwatch mode / run / clear.
- timeout  out  1  one-cycle pulse when the inactivity timeout fires.

## Operation
- States: NORMAL, CLK_IDLE, CLK_HOUR, CLK_MIN, ALM_IDLE, ALM_HOUR, ALM_MIN, SW_CLEAR, SW_RUN, SW_PAUSE; the ALM_* states are qualified by alarm_sel.
- NORMAL: B0→CLK_IDLE; else B1→SW_CLEAR.
- CLK_IDLE: B0→ALM_IDLE, alarm_sel=0; else B1→CLK_HOUR. CLK_HOUR: B1→CLK_MIN. CLK_MIN: B1→CLK_IDLE.
- ALM_IDLE: B0→ALM_IDLE with alarm_sel+1, or NORMAL with alarm_sel=0 if alarm_sel==NUM_ALARMS-1; else B1→ALM_HOUR. ALM_HOUR: B1→ALM_MIN. ALM_MIN: B1→ALM_IDLE, same alarm_sel.
- SW_CLEAR: B0→SW_RUN; else B1→NORMAL. SW_RUN: B0→SW_PAUSE; B1 ignored. SW_PAUSE: B0→SW_CLEAR; else B1→NORMAL.
- B0 and B1 in the same cycle: B0 wins in every state that uses both. In *_HOUR/*_MIN, B0 increments only and never changes state.
- Outputs are combinational from state: set_clock=CLK_*. alarm_set[alarm_sel]=ALM_*. stop=SW_*. stop_start=SW_RUN. stop_reset=SW_CLEAR.
- inc_hour = (CLK_HOUR|ALM_HOUR)&(B0|rpt). inc_min = same with *_MIN. rpt is the auto-repeat strobe.
- Auto-repeat: the hold counter clears when b0_held=0 or the state is not *_HOUR/*_MIN. It counts ticks while held. rpt fires on the tick that reaches REPEAT_DELAY, then on every REPEAT_PERIOD-th tick after that. The counter saturates and does not wrap.
- Timeout: the idle counter runs only in CLK_* and ALM_* states. It clears on any B0 or B1 pulse and on entering a setting mode. On the tick where it reaches IDLE_TIMEOUT: next state NORMAL, alarm_sel=0, timeout=1 for that cycle. A button pulse in the same cycle wins: no timeout, counter clears. Stopwatch states never time out.
- Illegal state encoding or alarm_sel≥NUM_ALARMS: return to NORMAL, alarm_sel=0.

## Timing
- Reset, synchronous: state NORMAL, alarm_sel 0, counters 0. All outputs 0 in the cycle after the reset edge. Reset asserted mid-operation takes effect at the next clk edge, from any state, with no strobe emitted.
- State changes on the clk edge that samples the pulse, so new mode outputs appear 1 cycle after the pulse.
- inc_* is same-cycle with B0 or with rpt (0 latency). Each is exactly one cycle.
- timeout and NORMAL outputs appear in the cycle after the terminal tick edge.

## Structure
- Package clock_mode_pkg: state enum; shared constants for the alarm-count limit and the index width function.
- Sub-module hold_repeat: parameters REPEAT_DELAY and REPEAT_PERIOD; inputs clk, reset, tick, b0_held and an enable; output rpt.

## Test plan
- Reset, then B0, B0, B0, B0 with NUM_ALARMS=2 → CLK_IDLE; alarm_set=01, alarm_sel=0; alarm_set=10, alarm_sel=1; NORMAL with all outputs 0.
- CLK_IDLE, B1 then B0 ×2 → inc_hour pulses twice, same cycles as B0. Then B1, B0 → inc_min=1. Then B1 → CLK_IDLE.
- ALM_HOUR, b0_held=1 for 6 ticks (DELAY=3, PERIOD=1) → rpt/inc_hour on ticks 3, 4, 5, 6. Release → no more strobes. A B1 mid-hold → ALM_MIN and the counter clears.
- CLK_MIN, IDLE_TIMEOUT=5, 5 ticks with no pulse → timeout=1 for 1 cycle, then NORMAL. A B1 on the 5th tick → stays in the setting path with no timeout.
- NORMAL, B1, B0, B0, B1 → stop_reset, then stop_start, then SW_PAUSE (stop only), then NORMAL. Simultaneous B0+B1 in SW_CLEAR → SW_RUN.
- Reset asserted in ALM_MIN with alarm_sel=1 and b0_held=1 → next cycle NORMAL, alarm_sel=0, no inc strobe.

Source files
------------

// File: rtl/clock_mode_pkg.sv
// -----------------------------------------------------------------------------
// clock_mode_pkg
// Shared types and helpers for the digital-clock mode controller.
//   state_e        : controller state encoding
//   MAX_ALARMS     : largest supported number of alarm channels
//   sel_width()    : width of the alarm index, never less than one bit
//   count_width()  : width of a counter that must hold 0..max
//   is_*()         : state-class decoders shared by the FSM and its outputs
// -----------------------------------------------------------------------------
package clock_mode_pkg;

   localparam int unsigned MAX_ALARMS = 4;

   typedef enum logic [3:0] {
      NORMAL   = 4'd0,
      CLK_IDLE = 4'd1,
      CLK_HOUR = 4'd2,
      CLK_MIN  = 4'd3,
      ALM_IDLE = 4'd4,
      ALM_HOUR = 4'd5,
      ALM_MIN  = 4'd6,
      SW_CLEAR = 4'd7,
      SW_RUN   = 4'd8,
      SW_PAUSE = 4'd9
   } state_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned count_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic logic is_clock(input state_e s);
      return (s == CLK_IDLE) || (s == CLK_HOUR) || (s == CLK_MIN);
   endfunction

   function automatic logic is_alarm(input state_e s);
      return (s == ALM_IDLE) || (s == ALM_HOUR) || (s == ALM_MIN);
   endfunction

   // Setting modes are the only ones subject to the inactivity timeout.
   function automatic logic is_setting(input state_e s);
      return is_clock(s) || is_alarm(s);
   endfunction

   function automatic logic is_hour(input state_e s);
      return (s == CLK_HOUR) || (s == ALM_HOUR);
   endfunction

   function automatic logic is_min(input state_e s);
      return (s == CLK_MIN) || (s == ALM_MIN);
   endfunction

endpackage

// File: rtl/hold_repeat.sv
// -----------------------------------------------------------------------------
// hold_repeat
// Auto-repeat generator for the increment button. While enabled and the
// button is held, ticks are counted; rpt fires on the tick that reaches
// REPEAT_DELAY and then on every REPEAT_PERIOD-th tick after that.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   tick       : one-cycle time-base enable
//   b0_held    : debounced level of the increment button
//   enable     : high while the controller sits in an hour/minute state
//   rpt        : one-cycle repeat strobe, same cycle as the qualifying tick
// -----------------------------------------------------------------------------
module hold_repeat
   import clock_mode_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 3,
   parameter int unsigned REPEAT_PERIOD = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic b0_held,
   input  logic enable,
   output logic rpt
);

   localparam int unsigned CNT_W = count_width(REPEAT_DELAY);
   localparam int unsigned PER_W = count_width(REPEAT_PERIOD);

   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] DELAY_FULL = CNT_W'(REPEAT_DELAY);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] hold_q, hold_d;
   logic [PER_W-1:0] per_q,  per_d;
   logic             rpt_raw;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the ifs can leave one unassigned and infer a latch.
      hold_d  = hold_q;
      per_d   = per_q;
      rpt_raw = 1'b0;

      if (!enable || !b0_held) begin
         hold_d = '0;
         per_d  = '0;
      end else if (tick) begin
         if (hold_q != DELAY_FULL) begin
            // Still in the initial delay; hold_q saturates at DELAY_FULL.
            hold_d = hold_q + CNT_W'(1);
            if (hold_q == DELAY_LAST) begin
               rpt_raw = 1'b1;
               per_d   = '0;
            end
         end else if (per_q == PER_LAST) begin
            rpt_raw = 1'b1;
            per_d   = '0;
         end else begin
            per_d = per_q + PER_W'(1);
         end
      end
   end

   // A strobe is never emitted in a cycle that is being reset.
   assign rpt = rpt_raw && !reset;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= '0;
         per_q  <= '0;
      end else begin
         hold_q <= hold_d;
         per_q  <= per_d;
      end
   end

endmodule

// File: rtl/clock_mode_fsm.sv
// -----------------------------------------------------------------------------
// clock_mode_fsm
// Mode controller for the digital clock. Decodes the two button pulses into
// clock-set, multi-alarm-set and stopwatch modes and drives the increment and
// stopwatch strobes. Adds hold-to-repeat on B0 and an inactivity timeout that
// drops setting modes back to NORMAL.
// Parameters:
//   NUM_ALARMS (1..4), REPEAT_DELAY, REPEAT_PERIOD, IDLE_TIMEOUT (all >= 1)
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   tick               : one-cycle time-base enable
//   B0, B1             : one-cycle button pulses (mode/increment, select)
//   b0_held            : debounced level of button 0
//   set_clock          : in a clock-set state
//   alarm_set          : one-hot, bit k in alarm-k set states
//   alarm_sel          : current alarm index
//   inc_hour, inc_min  : one-cycle increment strobes (same cycle as B0/rpt)
//   stop, stop_start, stop_reset : stopwatch mode / run / clear
//   timeout            : one-cycle pulse in the cycle after the timeout fires
// -----------------------------------------------------------------------------
module clock_mode_fsm
   import clock_mode_pkg::*;
#(
   parameter  int unsigned NUM_ALARMS    = 2,
   parameter  int unsigned REPEAT_DELAY  = 3,
   parameter  int unsigned REPEAT_PERIOD = 1,
   parameter  int unsigned IDLE_TIMEOUT  = 30,
   localparam int unsigned SEL_W         = sel_width(NUM_ALARMS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  B0,
   input  logic                  B1,
   input  logic                  b0_held,
   output logic                  set_clock,
   output logic [NUM_ALARMS-1:0] alarm_set,
   output logic [SEL_W-1:0]      alarm_sel,
   output logic                  inc_hour,
   output logic                  inc_min,
   output logic                  stop,
   output logic                  stop_start,
   output logic                  stop_reset,
   output logic                  timeout
);

   localparam int unsigned IDLE_W = count_width(IDLE_TIMEOUT);

   localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_ALARMS - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              timeout_q, timeout_d;
   logic              sel_ok;
   logic              rpt_en;
   logic              rpt;

   // An index at or beyond NUM_ALARMS can only come from an upset; it is
   // treated like an illegal state encoding.
   assign sel_ok = ({1'b0, sel_q} < (SEL_W + 1)'(NUM_ALARMS));

   // -------------------------------------------------------------------------
   // Next-state logic, alarm index and inactivity counter
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      idle_d    = '0;
      timeout_d = 1'b0;

      if (!sel_ok) begin
         state_d = NORMAL;
         sel_d   = '0;
      end else begin
         // B0 is tested first wherever both buttons matter, so it wins a tie.
         case (state_q)
            NORMAL: begin
               if (B0)      state_d = CLK_IDLE;
               else if (B1) state_d = SW_CLEAR;
            end
            CLK_IDLE: begin
               if (B0) begin
                  state_d = ALM_IDLE;
                  sel_d   = '0;
               end else if (B1) begin
                  state_d = CLK_HOUR;
               end
            end
            // In hour/minute states B0 only increments; a B1 arriving with
            // it is dropped.
            CLK_HOUR: if (!B0 && B1) state_d = CLK_MIN;
            CLK_MIN:  if (!B0 && B1) state_d = CLK_IDLE;
            ALM_IDLE: begin
               if (B0) begin
                  if (sel_q == LAST_SEL) begin
                     state_d = NORMAL;
                     sel_d   = '0;
                  end else begin
                     sel_d = sel_q + SEL_W'(1);
                  end
               end else if (B1) begin
                  state_d = ALM_HOUR;
               end
            end
            ALM_HOUR: if (!B0 && B1) state_d = ALM_MIN;
            ALM_MIN:  if (!B0 && B1) state_d = ALM_IDLE;
            SW_CLEAR: begin
               if (B0)      state_d = SW_RUN;
               else if (B1) state_d = NORMAL;
            end
            SW_RUN: if (B0) state_d = SW_PAUSE;
            SW_PAUSE: begin
               if (B0)      state_d = SW_CLEAR;
               else if (B1) state_d = NORMAL;
            end
            default: begin
               state_d = NORMAL;
               sel_d   = '0;
            end
         endcase

         // Inactivity timeout. idle_d defaults to zero, which covers the
         // stopwatch/NORMAL states and any button pulse; a pulse in the
         // terminal tick cycle therefore wins over the timeout.
         if (is_setting(state_q) && !B0 && !B1) begin
            if (tick) begin
               if (idle_q == IDLE_LAST) begin
                  state_d   = NORMAL;
                  sel_d     = '0;
                  timeout_d = 1'b1;
               end else begin
                  idle_d = idle_q + IDLE_W'(1);
               end
            end else begin
               idle_d = idle_q;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Auto-repeat: only armed while staying in an hour/minute state, so any
   // transition (B1 advance, timeout) restarts the hold count from zero.
   // -------------------------------------------------------------------------
   assign rpt_en = (is_hour(state_q) || is_min(state_q)) && (state_d == state_q);

   hold_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_hold_repeat (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .b0_held (b0_held),
      .enable  (rpt_en),
      .rpt     (rpt)
   );

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= NORMAL;
         sel_q     <= '0;
         idle_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: mode flags decode the registered state; increment strobes are
   // combinational with B0/rpt and suppressed while reset is asserted.
   // -------------------------------------------------------------------------
   always_comb begin
      set_clock  = is_clock(state_q);
      alarm_set  = '0;
      if (is_alarm(state_q) && sel_ok) begin
         alarm_set = NUM_ALARMS'(1) << sel_q;
      end
      alarm_sel  = sel_q;
      inc_hour   = !reset && is_hour(state_q) && (B0 || rpt);
      inc_min    = !reset && is_min(state_q)  && (B0 || rpt);
      stop       = (state_q == SW_CLEAR) || (state_q == SW_RUN) || (state_q == SW_PAUSE);
      stop_start = (state_q == SW_RUN);
      stop_reset = (state_q == SW_CLEAR);
      timeout    = timeout_q;
   end

endmodule

// File: tb/tb_clock_mode_fsm.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_fsm
// Self-checking bench for clock_mode_fsm (NUM_ALARMS=2, REPEAT_DELAY=3,
// REPEAT_PERIOD=1, IDLE_TIMEOUT=8). Each vector drives one cycle of inputs
// shortly after a rising edge and compares all outputs at the falling edge.
// Output word: {set_clock, alarm_set[1:0], alarm_sel, inc_hour, inc_min,
//               stop, stop_start, stop_reset, timeout}
// -----------------------------------------------------------------------------
module tb_clock_mode_fsm;

   localparam int unsigned NUM_ALARMS    = 2;
   localparam int unsigned REPEAT_DELAY  = 3;
   localparam int unsigned REPEAT_PERIOD = 1;
   localparam int unsigned IDLE_TIMEOUT  = 8;

   localparam logic [9:0] O_NONE = 10'h000;
   localparam logic [9:0] O_CLK  = 10'h200;
   localparam logic [9:0] O_ALM0 = 10'h080;
   localparam logic [9:0] O_ALM1 = 10'h140;
   localparam logic [9:0] INC_H  = 10'h020;
   localparam logic [9:0] INC_M  = 10'h010;
   localparam logic [9:0] O_SWC  = 10'h00A;
   localparam logic [9:0] O_SWR  = 10'h00C;
   localparam logic [9:0] O_SWP  = 10'h008;
   localparam logic [9:0] TMO    = 10'h001;

   typedef struct {
      string      name;
      logic       rst;
      logic       tck;
      logic       b0;
      logic       b1;
      logic       held;
      logic [9:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, tick, B0, B1, b0_held;
   logic       set_clock, inc_hour, inc_min, stop, stop_start, stop_reset, timeout;
   logic [1:0] alarm_set;
   logic [0:0] alarm_sel;

   vec_t       vecs[$];
   logic [9:0] exp_q[$];
   int         n_vec  = 0;
   int         n_miss = 0;

   clock_mode_fsm #(
      .NUM_ALARMS    (NUM_ALARMS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .IDLE_TIMEOUT  (IDLE_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .B0         (B0),
      .B1         (B1),
      .b0_held    (b0_held),
      .set_clock  (set_clock),
      .alarm_set  (alarm_set),
      .alarm_sel  (alarm_sel),
      .inc_hour   (inc_hour),
      .inc_min    (inc_min),
      .stop       (stop),
      .stop_start (stop_start),
      .stop_reset (stop_reset),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {set_clock, alarm_set, alarm_sel, inc_hour, inc_min,
              stop, stop_start, stop_reset, timeout};
   endfunction

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: outputs %03h, expected %03h", name, got, exp);
      end
   endtask

   task automatic add(input string name, input logic rst, input logic tck,
                      input logic b0, input logic b1, input logic held,
                      input logic [9:0] exp);
      vec_t v;
      v.name = name; v.rst = rst; v.tck = tck;
      v.b0 = b0; v.b1 = b1; v.held = held; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Drive one cycle, queue its expectation, compare at the falling edge.
   task automatic apply(input vec_t v);
      logic [9:0] e;
      @(posedge clk);
      #1;
      reset   = v.rst;
      tick    = v.tck;
      B0      = v.b0;
      B1      = v.b1;
      b0_held = v.held;
      exp_q.push_back(v.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      check(v.name, outs(), e);
   endtask

   task automatic step(input string name, input logic rst, input logic tck,
                       input logic b0, input logic b1, input logic held,
                       input logic [9:0] exp);
      vec_t v;
      v.name = name; v.rst = rst; v.tck = tck;
      v.b0 = b0; v.b1 = b1; v.held = held; v.exp = exp;
      apply(v);
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; B0 = 1'b0; B1 = 1'b0; b0_held = 1'b0;
      repeat (2) @(posedge clk);

      // ---- table: stopwatch, mode walk, increments, auto-repeat ----------
      //       name                rst tck b0 b1 held expected
      add("reset_state",          0, 0, 0, 0, 0, O_NONE);
      add("nrm_b1",               0, 0, 0, 1, 0, O_NONE);
      add("swc_b0",               0, 0, 1, 0, 0, O_SWC);
      add("swr_b1_ignored",       0, 0, 0, 1, 0, O_SWR);
      for (int i = 0; i < 9; i++)
         add("swr_tick_no_tmo",   0, 1, 0, 0, 0, O_SWR);
      add("swr_b0",               0, 0, 1, 0, 0, O_SWR);
      add("swp_quiet",            0, 0, 0, 0, 0, O_SWP);
      add("swp_b1",               0, 0, 0, 1, 0, O_SWP);
      add("nrm_after_sw",         0, 0, 0, 0, 0, O_NONE);
      add("nrm_b1_again",         0, 0, 0, 1, 0, O_NONE);
      add("swc_b0b1_b0_wins",     0, 0, 1, 1, 0, O_SWC);
      add("swr_after_tie",        0, 0, 0, 0, 0, O_SWR);
      add("swr_b0_again",         0, 0, 1, 0, 0, O_SWR);
      add("swp_b0",               0, 0, 1, 0, 0, O_SWP);
      add("swc_b1",               0, 0, 0, 1, 0, O_SWC);
      add("nrm_b0",               0, 0, 1, 0, 0, O_NONE);
      add("clk_idle",             0, 0, 0, 0, 0, O_CLK);
      add("clk_idle_b0",          0, 0, 1, 0, 0, O_CLK);
      add("alm0_idle",            0, 0, 0, 0, 0, O_ALM0);
      add("alm0_b0",              0, 0, 1, 0, 0, O_ALM0);
      add("alm1_idle",            0, 0, 0, 0, 0, O_ALM1);
      add("alm1_b0_wrap",         0, 0, 1, 0, 0, O_ALM1);
      add("nrm_after_alm",        0, 0, 0, 0, 0, O_NONE);
      add("nrm_b0_2",             0, 0, 1, 0, 0, O_NONE);
      add("clk_idle_b1",          0, 0, 0, 1, 0, O_CLK);
      add("clk_hour_b0_1",        0, 0, 1, 0, 0, O_CLK | INC_H);
      add("clk_hour_quiet",       0, 0, 0, 0, 0, O_CLK);
      add("clk_hour_b0_2",        0, 0, 1, 0, 0, O_CLK | INC_H);
      add("clk_hour_b1",          0, 0, 0, 1, 0, O_CLK);
      add("clk_min_b0",           0, 0, 1, 0, 0, O_CLK | INC_M);
      add("clk_min_b0b1_stays",   0, 0, 1, 1, 0, O_CLK | INC_M);
      add("clk_min_b1",           0, 0, 0, 1, 0, O_CLK);
      add("clk_idle_back",        0, 0, 0, 0, 0, O_CLK);
      add("clk_idle_b0_to_alm",   0, 0, 1, 0, 0, O_CLK);
      add("alm0_b1",              0, 0, 0, 1, 0, O_ALM0);
      add("alm_hour_b0",          0, 0, 1, 0, 0, O_ALM0 | INC_H);
      add("hold_tick1",           0, 1, 0, 0, 1, O_ALM0);
      add("hold_tick2",           0, 1, 0, 0, 1, O_ALM0);
      add("hold_no_tick",         0, 0, 0, 0, 1, O_ALM0);
      add("hold_tick3_rpt",       0, 1, 0, 0, 1, O_ALM0 | INC_H);
      add("hold_tick4_rpt",       0, 1, 0, 0, 1, O_ALM0 | INC_H);
      add("hold_tick5_rpt",       0, 1, 0, 0, 1, O_ALM0 | INC_H);
      add("hold_tick6_rpt",       0, 1, 0, 0, 1, O_ALM0 | INC_H);
      add("hold_release",         0, 0, 0, 0, 0, O_ALM0);
      add("rehold_tick1",         0, 1, 0, 0, 1, O_ALM0);
      add("hold_b1_to_min",       0, 0, 0, 1, 1, O_ALM0);
      add("min_hold_tick1",       0, 1, 0, 0, 1, O_ALM0);
      add("min_hold_tick2",       0, 1, 0, 0, 1, O_ALM0);
      add("min_hold_tick3_rpt",   0, 1, 0, 0, 1, O_ALM0 | INC_M);
      add("min_release",          0, 0, 0, 0, 0, O_ALM0);

      foreach (vecs[i]) apply(vecs[i]);

      // ---- reset asserted in ALM_MIN with alarm_sel=1 and b0 held ---------
      step("min_b1_to_idle",      0, 0, 0, 1, 0, O_ALM0);
      step("alm0_b0_sel1",        0, 0, 1, 0, 0, O_ALM0);
      step("alm1_b1_hour",        0, 0, 0, 1, 0, O_ALM1);
      step("alm1_hour_b1_min",    0, 0, 0, 1, 0, O_ALM1);
      step("alm1_min_b0",         0, 0, 1, 0, 1, O_ALM1 | INC_M);
      step("rst_in_alm_min",      1, 1, 0, 0, 1, O_ALM1);
      step("after_rst",           0, 1, 0, 0, 1, O_NONE);
      step("after_rst_quiet",     0, 0, 0, 0, 0, O_NONE);

      // ---- inactivity timeout: button wins on the terminal tick, then fires
      step("to_b0",               0, 0, 1, 0, 0, O_NONE);
      step("to_b1_hour",          0, 0, 0, 1, 0, O_CLK);
      step("to_b1_min",           0, 0, 0, 1, 0, O_CLK);
      for (int i = 0; i < 7; i++)
         step("to_min_tick",      0, 1, 0, 0, 0, O_CLK);
      step("to_b1_wins",          0, 1, 0, 1, 0, O_CLK);
      step("to_no_timeout",       0, 0, 0, 0, 0, O_CLK);
      for (int i = 0; i < 7; i++)
         step("to_idle_tick",     0, 1, 0, 0, 0, O_CLK);
      step("to_terminal_tick",    0, 1, 0, 0, 0, O_CLK);
      step("to_fired",            0, 0, 0, 0, 0, TMO);
      step("to_one_cycle",        0, 0, 0, 0, 0, O_NONE);

      // ---- timeout from alarm 1 returns alarm_sel to 0 --------------------
      step("ta_b0",               0, 0, 1, 0, 0, O_NONE);
      step("ta_b0_alm",           0, 0, 1, 0, 0, O_CLK);
      step("ta_b0_sel1",          0, 0, 1, 0, 0, O_ALM0);
      for (int i = 0; i < 7; i++)
         step("ta_alm1_tick",     0, 1, 0, 0, 0, O_ALM1);
      step("ta_terminal_tick",    0, 1, 0, 0, 0, O_ALM1);
      step("ta_fired",            0, 0, 0, 0, 0, TMO);
      step("ta_b0_again",         0, 0, 1, 0, 0, O_NONE);
      step("ta_b0_alm_again",     0, 0, 1, 0, 0, O_CLK);
      step("ta_sel_restarts_0",   0, 0, 0, 0, 0, O_ALM0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
